// File: rtl/snax_hwpe_tcdm_arbiter.sv
// ---------------------------------------------------------------------------
// snax_hwpe_tcdm_arbiter
//
// Round-robin arbiter that shares one HWPE TCDM master port among NumReq
// HWPE streamer ports. A selected requester stays locked onto the master
// port until its grant arrives. A small route FIFO remembers which requester
// issued each read, so that in-order read responses are steered back to the
// right requester.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   slv_*_i / slv_*_o per-requester HWPE request channel (flattened vectors,
//                     requester k occupies slice [k*W +: W])
//   slv_r_*_o         per-requester read response (same cycle as mst_r_*_i)
//   mst_*_o / mst_*_i single HWPE master port towards the reqrsp converter
//   rsp_err_o         pulse: a read response arrived with no route recorded
// ---------------------------------------------------------------------------
module snax_hwpe_tcdm_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumReq-1:0]                slv_req_i,
  output logic [NumReq-1:0]                slv_gnt_o,
  input  logic [NumReq*AddrWidth-1:0]      slv_add_i,
  input  logic [NumReq-1:0]                slv_wen_i,
  input  logic [NumReq*(DataWidth/8)-1:0]  slv_be_i,
  input  logic [NumReq*DataWidth-1:0]      slv_data_i,
  output logic [NumReq*DataWidth-1:0]      slv_r_data_o,
  output logic [NumReq-1:0]                slv_r_valid_o,
  output logic                             mst_req_o,
  input  logic                             mst_gnt_i,
  output logic [AddrWidth-1:0]             mst_add_o,
  output logic                             mst_wen_o,
  output logic [DataWidth/8-1:0]           mst_be_o,
  output logic [DataWidth-1:0]             mst_data_o,
  input  logic [DataWidth-1:0]             mst_r_data_i,
  input  logic                             mst_r_valid_i,
  output logic                             rsp_err_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned BeW  = DataWidth / 8;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] sel_q, sel_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

  // Route FIFO: one requester index per outstanding read. The extra MSB on
  // each pointer tells full from empty when the low bits coincide.
  logic [IdxW-1:0] route_q [MaxOutstanding];
  logic [PtrW:0]   wptr_q, rptr_q;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic [IdxW-1:0] head;

  logic [IdxW-1:0] winner, cand, cur_sel;
  logic            win_valid, req_act, done;

  // Unpacked views of the flattened requester buses.
  logic [AddrWidth-1:0] add_arr  [NumReq];
  logic [BeW-1:0]       be_arr   [NumReq];
  logic [DataWidth-1:0] data_arr [NumReq];

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                      (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign head       = route_q[rptr_q[PtrW-1:0]];

  // Round-robin search starting at rr_ptr_q. Full blocks new selections only;
  // an already locked request is allowed to finish.
  always_comb begin
    winner    = '0;
    win_valid = 1'b0;
    cand      = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      cand = IdxW'((int'(rr_ptr_q) + i) % int'(NumReq));
      if (!win_valid && slv_req_i[cand] && !fifo_full) begin
        winner    = cand;
        win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cur_sel  = sel_q;
    req_act  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          cur_sel = winner;
          sel_d   = winner;
          req_act = 1'b1;
          if (!mst_gnt_i) state_d = LOCKED;
        end
      end
      LOCKED: begin
        // A requester withdrawing before grant simply releases the port.
        req_act = slv_req_i[sel_q];
        if (!req_act || mst_gnt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is forced low while reset is asserted.
  assign mst_req_o  = req_act && !rst_i;
  assign done       = mst_req_o && mst_gnt_i;
  assign mst_add_o  = mst_req_o ? add_arr[cur_sel]  : '0;
  assign mst_wen_o  = mst_req_o ? slv_wen_i[cur_sel] : 1'b0;
  assign mst_be_o   = mst_req_o ? be_arr[cur_sel]   : '0;
  assign mst_data_o = mst_req_o ? data_arr[cur_sel] : '0;

  assign rr_ptr_d = !done ? rr_ptr_q :
                    (cur_sel == IdxW'(NumReq - 1)) ? '0 : cur_sel + 1'b1;

  assign push      = done && mst_wen_o;
  assign pop       = mst_r_valid_i && !fifo_empty && !rst_i;
  assign rsp_err_o = mst_r_valid_i && fifo_empty && !rst_i;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_port
    assign add_arr[gi]   = slv_add_i[gi*AddrWidth +: AddrWidth];
    assign be_arr[gi]    = slv_be_i[gi*BeW +: BeW];
    assign data_arr[gi]  = slv_data_i[gi*DataWidth +: DataWidth];
    assign slv_gnt_o[gi] = done && (cur_sel == IdxW'(gi));
    assign slv_r_valid_o[gi] = pop && (head == IdxW'(gi));
    assign slv_r_data_o[gi*DataWidth +: DataWidth] =
      slv_r_valid_o[gi] ? mst_r_data_i : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Route storage needs no reset: pointers alone define which entries are live.
  // With push and pop on a full FIFO the written slot is the one being read;
  // the head is consumed combinationally before the write lands.
  always_ff @(posedge clk_i) begin
    if (push) route_q[wptr_q[PtrW-1:0]] <= cur_sel;
  end

endmodule

// File: tb/tb_snax_hwpe_tcdm_arbiter.sv
module tb_snax_hwpe_tcdm_arbiter;
  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    slv_req;
  logic [NR-1:0]    slv_gnt;
  logic [NR*AW-1:0] slv_add;
  logic [NR-1:0]    slv_wen;
  logic [NR*4-1:0]  slv_be;
  logic [NR*DW-1:0] slv_data;
  logic [NR*DW-1:0] slv_r_data;
  logic [NR-1:0]    slv_r_valid;
  logic             mst_req, mst_gnt, mst_wen, mst_r_valid, rsp_err;
  logic [AW-1:0]    mst_add;
  logic [3:0]       mst_be;
  logic [DW-1:0]    mst_data, mst_r_data;

  always #5 clk = ~clk;

  snax_hwpe_tcdm_arbiter #(
    .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_req_i(slv_req), .slv_gnt_o(slv_gnt), .slv_add_i(slv_add),
    .slv_wen_i(slv_wen), .slv_be_i(slv_be), .slv_data_i(slv_data),
    .slv_r_data_o(slv_r_data), .slv_r_valid_o(slv_r_valid),
    .mst_req_o(mst_req), .mst_gnt_i(mst_gnt), .mst_add_o(mst_add),
    .mst_wen_o(mst_wen), .mst_be_o(mst_be), .mst_data_o(mst_data),
    .mst_r_data_i(mst_r_data), .mst_r_valid_i(mst_r_valid), .rsp_err_o(rsp_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending requester, next round-robin start, and an
  // ordered list of requesters owed a read response.
  int pend = -1;
  int rr = 0;
  int rq[$];
  int last_sel = -1;

  int            exp_sel;
  logic          exp_req, exp_done, exp_pop, exp_err;
  logic [NR-1:0] exp_gnt, exp_rvalid;
  logic [NR*DW-1:0] exp_rdata;
  logic [AW-1:0] exp_add;
  logic          exp_wen;
  logic [3:0]    exp_be;
  logic [DW-1:0] exp_data;

  // Values seen at the latest sample point, for directed checks.
  logic [NR-1:0]    cap_gnt, cap_rvalid;
  logic [NR*DW-1:0] cap_rdata;
  logic             cap_req, cap_err;
  logic [AW-1:0]    cap_add;
  logic [DW-1:0]    cap_data;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_expect();
    exp_sel = -1;
    if (!rst) begin
      if (pend >= 0) begin
        if (slv_req[pend]) exp_sel = pend;
      end else if (rq.size() < MO) begin
        for (int k = 0; k < NR; k++)
          if (exp_sel < 0 && slv_req[(rr + k) % NR]) exp_sel = (rr + k) % NR;
      end
    end
    exp_req = (exp_sel >= 0);
    exp_add = '0; exp_wen = 1'b0; exp_be = '0; exp_data = '0; exp_gnt = '0;
    if (exp_req) begin
      exp_add  = slv_add[exp_sel*AW +: AW];
      exp_wen  = slv_wen[exp_sel];
      exp_be   = slv_be[exp_sel*4 +: 4];
      exp_data = slv_data[exp_sel*DW +: DW];
    end
    exp_done = exp_req && mst_gnt;
    if (exp_done) exp_gnt[exp_sel] = 1'b1;
    exp_pop    = !rst && mst_r_valid && (rq.size() > 0);
    exp_err    = !rst && mst_r_valid && (rq.size() == 0);
    exp_rvalid = '0;
    exp_rdata  = '0;
    if (exp_pop) begin
      exp_rvalid[rq[0]] = 1'b1;
      exp_rdata[rq[0]*DW +: DW] = mst_r_data;
    end
  endtask

  task automatic model_update();
    last_sel = -1;
    if (rst) begin
      pend = -1; rr = 0; rq.delete();
    end else begin
      if (exp_pop) void'(rq.pop_front());
      if (exp_done) begin
        rr = (exp_sel + 1) % NR;
        if (slv_wen[exp_sel]) rq.push_back(exp_sel);
        pend = -1;
        last_sel = exp_sel;
      end else begin
        pend = exp_sel;
      end
    end
  endtask

  // One clock: inputs already driven after a negedge; sample, check, advance.
  task automatic step();
    #1;
    model_expect();
    check("mst_req", mst_req, exp_req);
    check("mst_add", mst_add, exp_add);
    check("mst_wen", mst_wen, exp_wen);
    check("mst_be", mst_be, exp_be);
    check("mst_data", mst_data, exp_data);
    check("slv_gnt", slv_gnt, exp_gnt);
    check("slv_r_valid", slv_r_valid, exp_rvalid);
    check("slv_r_data", slv_r_data, exp_rdata);
    check("rsp_err", rsp_err, exp_err);
    cap_gnt = slv_gnt; cap_rvalid = slv_r_valid; cap_rdata = slv_r_data;
    cap_req = mst_req; cap_err = rsp_err; cap_add = mst_add; cap_data = mst_data;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] d);
    slv_req[r] = 1'b1;
    slv_add[r*AW +: AW] = a;
    slv_wen[r] = w;
    slv_be[r*4 +: 4] = b;
    slv_data[r*DW +: DW] = d;
  endtask

  task automatic clear_in();
    slv_req = '0; slv_add = '0; slv_wen = '0; slv_be = '0; slv_data = '0;
    mst_gnt = 1'b0; mst_r_valid = 1'b0; mst_r_data = '0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int order[5] = '{0, 1, 2, 3, 0};
  logic [NR-1:0] one_hot;

  initial begin
    clear_in();
    rst = 1'b1;
    @(negedge clk);

    // Reset held 3 cycles with all requesters active.
    for (int r = 0; r < NR; r++) set_req(r, 32'h100 + r, 1'b0, 4'hF, 32'h55 + r);
    mst_gnt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("reset_req", cap_req, 1'b0);
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      one_hot = '0; one_hot[order[k]] = 1'b1;
      check("rr_order", cap_gnt, one_hot);
    end

    // Requester 2 locked while the grant is held back; 1 joins meanwhile.
    do_reset();
    set_req(2, 32'h1000_0004, 1'b1, 4'hF, 32'h0);
    step();
    check("lock_add", cap_add, 32'h1000_0004);
    set_req(1, 32'h1000_0100, 1'b1, 4'hF, 32'h0);
    for (int k = 0; k < 2; k++) begin
      step();
      check("lock_add", cap_add, 32'h1000_0004);
    end
    mst_gnt = 1'b1;
    step();
    check("lock_gnt", cap_gnt, 4'b0100);
    slv_req[2] = 1'b0;
    set_req(0, 32'h1000_0200, 1'b0, 4'h3, 32'h1234);
    step();
    check("after_lock", cap_gnt, 4'b0001);

    // In-order read routing: 0, 3, 0.
    do_reset();
    mst_gnt = 1'b1;
    set_req(0, 32'h10, 1'b1, 4'hF, 0); step(); slv_req = '0;
    set_req(3, 32'h20, 1'b1, 4'hF, 0); step(); slv_req = '0;
    set_req(0, 32'h30, 1'b1, 4'hF, 0); step(); slv_req = '0;
    mst_r_valid = 1'b1;
    mst_r_data = 32'hA; step();
    check("route_a", cap_rdata, 128'hA);
    mst_r_data = 32'hB; step();
    check("route_b", cap_rdata, {32'hB, 96'h0});
    mst_r_data = 32'hC; step();
    check("route_c", cap_rvalid, 4'b0001);
    mst_r_valid = 1'b0;

    // Route FIFO full with requester 1 streaming reads.
    do_reset();
    mst_gnt = 1'b1;
    set_req(1, 32'h2000, 1'b1, 4'hF, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("fill_gnt", cap_gnt, 4'b0010);
    end
    step();
    check("full_block", cap_req, 1'b0);
    mst_r_valid = 1'b1; mst_r_data = 32'h77; step();
    check("full_pop", cap_rvalid, 4'b0010);
    check("full_pop_req", cap_req, 1'b0);
    mst_r_valid = 1'b0; step();
    check("ninth_gnt", cap_gnt, 4'b0010);
    step();
    check("refull_block", cap_req, 1'b0);
    mst_r_valid = 1'b1; step();
    step();
    check("pushpop_gnt", cap_gnt, 4'b0010);
    mst_r_valid = 1'b0; step();
    check("pushpop_next", cap_gnt, 4'b0010);
    step();
    check("pushpop_full", cap_req, 1'b0);

    // Write passes through untouched; a stray response flags an error.
    do_reset();
    mst_gnt = 1'b1;
    set_req(2, 32'h3000, 1'b0, 4'hF, 32'hDEAD_BEEF);
    step();
    check("wr_data", cap_data, 32'hDEAD_BEEF);
    check("wr_gnt", cap_gnt, 4'b0100);
    slv_req = '0;
    mst_r_valid = 1'b1; step();
    check("spur_err", cap_err, 1'b1);
    check("spur_rvalid", cap_rvalid, 4'b0000);
    mst_r_valid = 1'b0; step();
    check("spur_err_end", cap_err, 1'b0);

    // Reset while locked with three reads outstanding.
    do_reset();
    mst_gnt = 1'b1;
    for (int r = 0; r < 3; r++) begin
      set_req(r, 32'h4000 + r, 1'b1, 4'hF, 0); step(); slv_req = '0;
    end
    mst_gnt = 1'b0;
    set_req(3, 32'h4003, 1'b1, 4'hF, 0); step();
    rst = 1'b1; step();
    rst = 1'b0; clear_in(); step();
    check("post_rst_req", cap_req, 1'b0);
    mst_r_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mst_r_data = 32'h900 + k; step();
      check("late_err", cap_err, 1'b1);
      check("late_rvalid", cap_rvalid, 4'b0000);
    end
    mst_r_valid = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int r = 0; r < NR; r++) begin
        if (!slv_req[r] || last_sel == r) begin
          if ($urandom_range(0, 1) == 1)
            set_req(r, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
          else
            slv_req[r] = 1'b0;
        end else if ($urandom_range(0, 63) == 0) begin
          slv_req[r] = 1'b0;
        end
      end
      mst_gnt     = ($urandom_range(0, 2) != 0);
      mst_r_valid = (rq.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      mst_r_data  = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
